pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Pipeline control unit for the 5-stage Y86-64 core. From stage icodes, register IDs, branch outcome
//  and status codes it generates stall/bubble controls for the F/D/E/M/W pipeline registers and the
//  condition-code write enable. It also runs the core's run/drain/halt state machine.
//  Sits beside the decode stage's forwarding logic and resolves the hazards forwarding cannot cover.
// PARAMETERS
//  CNT_W      32   width of each performance counter (PIPE_PERF_CNT_EN only)
// PORTS
//  clk          in   1      core clock; all state updates on rising edge
//  rst_n        in   1      synchronous reset, active-low
//  D_icode      in   4      icode in D register
//  d_srcA       in   4      decode-stage srcA (4'hF = RNONE)
//  d_srcB       in   4      decode-stage srcB (4'hF = RNONE)
//  E_icode      in   4      icode in E register
//  E_dstM       in   4      dstM in E register
//  e_Cnd        in   1      branch condition computed in execute
//  M_icode      in   4      icode in M register
//  m_stat       in   4      status leaving memory stage
//  W_stat       in   4      status in W register
//  F_stall      out  1      hold F (PC) register
//  D_stall      out  1      hold D register
//  D_bubble     out  1      load nop into D
//  E_bubble     out  1      load nop into E
//  M_bubble     out  1      load nop into M
//  W_stall      out  1      hold W register
//  set_cc       out  1      CC write enable for OPq in execute
//  halted       out  1      state machine is in HALTED
//  cpu_stat     out  4      final status latched on entering HALTED
// BEHAVIOUR
//  Constants: AOK=1 HLT=2 ADR=3 INS=4; IMRMOVQ=5 IOPQ=6 IJXX=7 IRET=9 IPOPQ=B; RNONE=F.
//  exc(s) = s in {HLT,ADR,INS}.
//  lu  = E_icode in {5,B} && E_dstM!=RNONE && (E_dstM==d_srcA || E_dstM==d_srcB).
//  mis = E_icode==7 && !e_Cnd.   ret = IRET in {D_icode,E_icode,M_icode}.
//  Outputs are combinational, zero latency. The values below apply in state RUN or DRAIN:
//   F_stall=lu|ret; D_stall=lu; D_bubble=mis|(ret&!lu); E_bubble=mis|lu;
//   M_bubble=exc(m_stat)|exc(W_stat); W_stall=exc(W_stat);
//   set_cc=(E_icode==6)&!exc(m_stat)&!exc(W_stat).
//  D_stall and D_bubble are never both 1. lu together with ret gives stall priority: D holds, E bubbles.
//  FSM (registered):
//   RUN    -> DRAIN  when exc(m_stat).
//   DRAIN  -> HALTED when exc(W_stat); cpu_stat<=W_stat.
//   RUN    -> HALTED directly if exc(W_stat) (W check wins over m check).
//   HALTED is absorbing until reset.
//   HALTED forces F_stall=D_stall=E_bubble=M_bubble=W_stall=1, D_bubble=0, set_cc=0, halted=1.
//  Reset (rst_n=0 sampled at edge): state<=RUN, cpu_stat<=AOK, counters<=0.
//   While rst_n=0 the combinational outputs are forced to F_stall=D_stall=W_stall=0,
//   D_bubble=E_bubble=M_bubble=1, set_cc=0, halted=0. This flushes the pipe.
//   Reset mid-DRAIN or in HALTED returns to RUN on the next edge.
//  Unknown stat values (0, >4) are treated as AOK.
// CONFIGURATION
//  PIPE_PERF_CNT_EN defined: adds outputs cyc_cnt, lu_cnt, mis_cnt, ret_cnt [CNT_W-1:0].
//   Counters increment once per cycle in RUN/DRAIN while rst_n=1:
//   cyc_cnt every cycle; lu_cnt on lu; mis_cnt on mis; ret_cnt on ret&!lu.
//   Counters saturate at all-ones, freeze in HALTED, and clear on reset.
//  Undefined: no counter ports or logic; all other behaviour identical.
// STRUCTURE
//  Package y86_pkg: icode localparams, stat codes, RNONE/RRSP, FSM state enum (RUN,DRAIN,HALTED).
//  Sub-module pipe_hazard_detect: purely combinational lu/mis/ret/exc decode.
//   The top level holds the FSM, the output override muxing and the optional counters.
// TESTING
//  Load-use: E_icode=5,E_dstM=3,d_srcA=3 -> F_stall=1,D_stall=1,E_bubble=1,D_bubble=0.
//  RNONE guard: E_icode=B,E_dstM=F,d_srcB=F -> lu=0, all controls 0.
//  Mispredict: E_icode=7,e_Cnd=0 -> D_bubble=1,E_bubble=1,F_stall=0; with e_Cnd=1 all 0.
//  Ret: D_icode=9 for 1 cycle then E, then M -> F_stall=1,D_bubble=1 for 3 cycles;
//   add lu in the same cycle -> D_stall=1,D_bubble=0.
//  Halt: m_stat=3 then W_stat=3 next cycle -> M_bubble=1 both cycles, state RUN->DRAIN->HALTED,
//   cpu_stat=3, set_cc=0 throughout.
//  Reset in HALTED: rst_n=0 for 1 edge -> halted=0, cpu_stat=1, bubbles D/E/M=1 while low,
//   counters=0 (PIPE_PERF_CNT_EN).

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings and pipeline-control state for the hazard controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package y86_pkg;

  // Instruction codes consulted by hazard detection
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPOPQ   = 4'hB;

  // Status codes
  localparam logic [3:0] STAT_AOK = 4'h1;
  localparam logic [3:0] STAT_HLT = 4'h2;
  localparam logic [3:0] STAT_ADR = 4'h3;
  localparam logic [3:0] STAT_INS = 4'h4;

  // Register IDs
  localparam logic [3:0] RRSP  = 4'h4;
  localparam logic [3:0] RNONE = 4'hF;

  // Core run/drain/halt state
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } pipe_state_e;

  // Exceptional status; unknown encodings (0, >4) count as AOK
  function automatic logic is_exc(input logic [3:0] s);
    return (s == STAT_HLT) || (s == STAT_ADR) || (s == STAT_INS);
  endfunction

endpackage

// File: rtl/pipe_hazard_detect.sv
// Combinational decode of load-use, mispredict, ret-in-flight and stage exceptions.
// Latency: zero cycles, purely combinational.
// Backpressure: none; results feed the controller's stall/bubble muxing.
module pipe_hazard_detect
  import y86_pkg::*;
(
  input  logic [3:0] D_icode,
  input  logic [3:0] d_srcA,
  input  logic [3:0] d_srcB,
  input  logic [3:0] E_icode,
  input  logic [3:0] E_dstM,
  input  logic       e_Cnd,
  input  logic [3:0] M_icode,
  input  logic [3:0] m_stat,
  input  logic [3:0] W_stat,
  output logic       lu,
  output logic       mis,
  output logic       ret,
  output logic       m_exc,
  output logic       w_exc
);

  // Hazard terms; RNONE in E_dstM never matches so an RNONE source cannot trigger lu
  always_comb begin
    lu    = ((E_icode == IMRMOVQ) || (E_icode == IPOPQ)) && (E_dstM != RNONE) &&
            ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    mis   = (E_icode == IJXX) && !e_Cnd;
    ret   = (D_icode == IRET) || (E_icode == IRET) || (M_icode == IRET);
    m_exc = is_exc(m_stat);
    w_exc = is_exc(W_stat);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Y86-64 pipeline control: stall/bubble generation, CC enable and run/drain/halt FSM.
// Latency: controls are combinational (zero cycles); FSM and cpu_stat update on the next edge.
// Backpressure: F/D stall on load-use or ret; HALTED freezes the whole pipe until reset.
// Optional performance counters are built when PIPE_PERF_CNT_EN is defined.
module pipe_hazard_ctrl
  import y86_pkg::*;
`ifdef PIPE_PERF_CNT_EN
#(
  parameter int CNT_W = 32
)
`endif
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] D_icode,
  input  logic [3:0] d_srcA,
  input  logic [3:0] d_srcB,
  input  logic [3:0] E_icode,
  input  logic [3:0] E_dstM,
  input  logic       e_Cnd,
  input  logic [3:0] M_icode,
  input  logic [3:0] m_stat,
  input  logic [3:0] W_stat,
  output logic       F_stall,
  output logic       D_stall,
  output logic       D_bubble,
  output logic       E_bubble,
  output logic       M_bubble,
  output logic       W_stall,
  output logic       set_cc,
  output logic       halted,
  output logic [3:0] cpu_stat
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] lu_cnt,
  output logic [CNT_W-1:0] mis_cnt,
  output logic [CNT_W-1:0] ret_cnt
`endif
);

  logic lu, mis, ret, m_exc, w_exc;

  pipe_state_e state_q, state_d;
  logic [3:0]  cpu_stat_q, cpu_stat_d;

  pipe_hazard_detect u_detect (
    .D_icode (D_icode),
    .d_srcA  (d_srcA),
    .d_srcB  (d_srcB),
    .E_icode (E_icode),
    .E_dstM  (E_dstM),
    .e_Cnd   (e_Cnd),
    .M_icode (M_icode),
    .m_stat  (m_stat),
    .W_stat  (W_stat),
    .lu      (lu),
    .mis     (mis),
    .ret     (ret),
    .m_exc   (m_exc),
    .w_exc   (w_exc)
  );

  // Next-state: a W exception halts from RUN or DRAIN and wins over an m exception
  always_comb begin
    state_d    = state_q;
    cpu_stat_d = cpu_stat_q;
    unique case (state_q)
      RUN: begin
        if (w_exc) begin
          state_d    = HALTED;
          cpu_stat_d = W_stat;
        end else if (m_exc) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (w_exc) begin
          state_d    = HALTED;
          cpu_stat_d = W_stat;
        end
      end
      HALTED: state_d = HALTED;
      default: state_d = RUN;
    endcase
  end

  // State and final-status registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= RUN;
      cpu_stat_q <= STAT_AOK;
    end else begin
      state_q    <= state_d;
      cpu_stat_q <= cpu_stat_d;
    end
  end

  // Output muxing: reset flushes the pipe, HALTED freezes it, otherwise hazard controls
  always_comb begin
    F_stall  = lu | ret;
    D_stall  = lu;
    D_bubble = mis | (ret & !lu);
    E_bubble = mis | lu;
    M_bubble = m_exc | w_exc;
    W_stall  = w_exc;
    set_cc   = (E_icode == IOPQ) & !m_exc & !w_exc;
    halted   = 1'b0;
    if (!rst_n) begin
      F_stall  = 1'b0;
      D_stall  = 1'b0;
      D_bubble = 1'b1;
      E_bubble = 1'b1;
      M_bubble = 1'b1;
      W_stall  = 1'b0;
      set_cc   = 1'b0;
    end else if (state_q == HALTED) begin
      F_stall  = 1'b1;
      D_stall  = 1'b1;
      D_bubble = 1'b0;
      E_bubble = 1'b1;
      M_bubble = 1'b1;
      W_stall  = 1'b1;
      set_cc   = 1'b0;
      halted   = 1'b1;
    end
  end

  assign cpu_stat = cpu_stat_q;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] cyc_cnt_q, cyc_cnt_d;
  logic [CNT_W-1:0] lu_cnt_q, lu_cnt_d;
  logic [CNT_W-1:0] mis_cnt_q, mis_cnt_d;
  logic [CNT_W-1:0] ret_cnt_q, ret_cnt_d;
  logic             cnt_en;

  // Saturating event counters, frozen once HALTED
  always_comb begin
    cnt_en    = (state_q != HALTED);
    cyc_cnt_d = cyc_cnt_q;
    lu_cnt_d  = lu_cnt_q;
    mis_cnt_d = mis_cnt_q;
    ret_cnt_d = ret_cnt_q;
    if (cnt_en) begin
      if (cyc_cnt_q != '1)              cyc_cnt_d = cyc_cnt_q + 1'b1;
      if (lu && (lu_cnt_q != '1))       lu_cnt_d  = lu_cnt_q + 1'b1;
      if (mis && (mis_cnt_q != '1))     mis_cnt_d = mis_cnt_q + 1'b1;
      if (ret && !lu && (ret_cnt_q != '1)) ret_cnt_d = ret_cnt_q + 1'b1;
    end
  end

  // Counter registers, cleared by reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cyc_cnt_q <= '0;
      lu_cnt_q  <= '0;
      mis_cnt_q <= '0;
      ret_cnt_q <= '0;
    end else begin
      cyc_cnt_q <= cyc_cnt_d;
      lu_cnt_q  <= lu_cnt_d;
      mis_cnt_q <= mis_cnt_d;
      ret_cnt_q <= ret_cnt_d;
    end
  end

  assign cyc_cnt = cyc_cnt_q;
  assign lu_cnt  = lu_cnt_q;
  assign mis_cnt = mis_cnt_q;
  assign ret_cnt = ret_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: hazard controls, FSM halt paths and reset flush.
// Latency: controls checked 1 time unit after inputs change; state checked after each edge.
// Backpressure: n/a.
module tb_pipe_hazard_ctrl;

  logic       clk;
  logic       rst_n;
  logic [3:0] D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode, m_stat, W_stat;
  logic       e_Cnd;
  logic       F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc, halted;
  logic [3:0] cpu_stat;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] cyc_cnt, lu_cnt, mis_cnt, ret_cnt;
`endif

  // Control bundle: {F_stall,D_stall,D_bubble,E_bubble,M_bubble,W_stall,set_cc,halted}
  logic [7:0] ctl;
  assign ctl = {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc, halted};

  int checks   = 0;
  int failures = 0;

  pipe_hazard_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .D_icode  (D_icode),
    .d_srcA   (d_srcA),
    .d_srcB   (d_srcB),
    .E_icode  (E_icode),
    .E_dstM   (E_dstM),
    .e_Cnd    (e_Cnd),
    .M_icode  (M_icode),
    .m_stat   (m_stat),
    .W_stat   (W_stat),
    .F_stall  (F_stall),
    .D_stall  (D_stall),
    .D_bubble (D_bubble),
    .E_bubble (E_bubble),
    .M_bubble (M_bubble),
    .W_stall  (W_stall),
    .set_cc   (set_cc),
    .halted   (halted),
    .cpu_stat (cpu_stat)
`ifdef PIPE_PERF_CNT_EN
    ,
    .cyc_cnt  (cyc_cnt),
    .lu_cnt   (lu_cnt),
    .mis_cnt  (mis_cnt),
    .ret_cnt  (ret_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    D_icode = 4'h1; d_srcA = 4'hF; d_srcB = 4'hF;
    E_icode = 4'h1; E_dstM = 4'hF; e_Cnd = 1'b0;
    M_icode = 4'h1; m_stat = 4'h1; W_stat = 4'h1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset flush
    idle();
    rst_n = 1'b0;
    #1;
    chk("rst_ctl", ctl, 8'b0011_1000);
    tick();
    chk("rst_stat", cpu_stat, 4'h1);
    chk("rst_ctl_edge", ctl, 8'b0011_1000);
    rst_n = 1'b1;
    #1;
    chk("run_idle", ctl, 8'b0000_0000);

    // Load-use through srcA (mrmovq) and srcB (popq)
    E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3;
    #1 chk("lu_srcA", ctl, 8'b1101_0000);
    idle();
    E_icode = 4'hB; E_dstM = 4'h4; d_srcB = 4'h4;
    #1 chk("lu_srcB", ctl, 8'b1101_0000);

    // RNONE guard
    idle();
    E_icode = 4'hB; E_dstM = 4'hF; d_srcB = 4'hF;
    #1 chk("rnone", ctl, 8'b0000_0000);

    // Mispredict and taken branch
    idle();
    E_icode = 4'h7; e_Cnd = 1'b0;
    #1 chk("mis", ctl, 8'b0011_0000);
    e_Cnd = 1'b1;
    #1 chk("jxx_taken", ctl, 8'b0000_0000);

    // OPq CC enable, blocked by a memory exception (no edge while m_stat is bad)
    idle();
    E_icode = 4'h6;
    #1 chk("opq_cc", ctl, 8'b0000_0010);
    m_stat = 4'h3;
    #1 chk("opq_mexc", ctl, 8'b0000_1000);
    m_stat = 4'h1;

    // Ret walking D -> E -> M
    idle();
    D_icode = 4'h9;
    #1 chk("ret_D", ctl, 8'b1010_0000);
    tick();
    D_icode = 4'h1; E_icode = 4'h9;
    #1 chk("ret_E", ctl, 8'b1010_0000);
    tick();
    E_icode = 4'h1; M_icode = 4'h9;
    #1 chk("ret_M", ctl, 8'b1010_0000);
    E_icode = 4'h5; E_dstM = 4'h2; d_srcA = 4'h2;
    #1 chk("ret_lu", ctl, 8'b1101_0000);
    idle();
    M_icode = 4'h9; E_icode = 4'h7; e_Cnd = 1'b0;
    #1 chk("ret_mis", ctl, 8'b1011_0000);

    // Unknown stat codes behave as AOK
    idle();
    E_icode = 4'h6; m_stat = 4'h0; W_stat = 4'h7;
    #1 chk("unk_stat", ctl, 8'b0000_0010);
    tick();
    chk("unk_stat_run", ctl, 8'b0000_0010);

    // Halt via DRAIN
    idle();
    E_icode = 4'h6; m_stat = 4'h3;
    #1 chk("halt_m", ctl, 8'b0000_1000);
    tick();
    m_stat = 4'h1;
    #1 chk("drain_idle", ctl, 8'b0000_0010);
    tick();
    W_stat = 4'h3;
    #1 chk("drain_w", ctl, 8'b0000_1100);
    tick();
    W_stat = 4'h1;
    #1 chk("halted_ctl", ctl, 8'b1101_1101);
    chk("halted_stat", cpu_stat, 4'h3);
    m_stat = 4'h4; W_stat = 4'h2;
    tick();
    chk("halted_abs", ctl, 8'b1101_1101);
    chk("halted_stat_hold", cpu_stat, 4'h3);

    // Reset from HALTED
    idle();
    rst_n = 1'b0;
    #1 chk("rst_halt_ctl", ctl, 8'b0011_1000);
    tick();
    chk("rst_halt_stat", cpu_stat, 4'h1);
`ifdef PIPE_PERF_CNT_EN
    chk("cnt_clr_cyc", cyc_cnt, 32'd0);
    chk("cnt_clr_lu", lu_cnt, 32'd0);
`endif
    rst_n = 1'b1;
    #1 chk("rst_halt_run", ctl, 8'b0000_0000);

`ifdef PIPE_PERF_CNT_EN
    // One cycle each of lu, mis, ret, idle
    E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3;
    tick();
    idle(); E_icode = 4'h7;
    tick();
    idle(); D_icode = 4'h9;
    tick();
    idle();
    tick();
    chk("cnt_cyc", cyc_cnt, 32'd4);
    chk("cnt_lu", lu_cnt, 32'd1);
    chk("cnt_mis", mis_cnt, 32'd1);
    chk("cnt_ret", ret_cnt, 32'd1);
`endif

    // Direct RUN -> HALTED: W exception wins over simultaneous m exception
    idle();
    m_stat = 4'h4; W_stat = 4'h2;
    #1 chk("direct_w", ctl, 8'b0000_1100);
    tick();
    idle();
    #1 chk("direct_halted", ctl, 8'b1101_1101);
    chk("direct_stat", cpu_stat, 4'h2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
